// File: rtl/l1d_cache_pkg.sv
// Shared types and tree-PLRU helpers for the N-way L1D cache controller.
// Helpers work on a fixed 8-way-wide encoding; callers pass the real index width.
package l1d_cache_pkg;

    typedef enum logic [2:0] {
        READY      = 3'd0,
        WB_LOAD    = 3'd1,
        WB_WRITE   = 3'd2,
        FILL_READ  = 3'd3,
        FILL_WRITE = 3'd4
    } state_e;

    localparam int unsigned MAX_WAYS  = 8;
    localparam int unsigned MAX_NODES = MAX_WAYS - 1;
    localparam int unsigned MAX_IDX_W = 3;

    // Walk from the root; bit 0 sends the walk to the left child (2k+1).
    function automatic logic [MAX_IDX_W-1:0] plru_victim(input int unsigned idx_w,
                                                         input logic [MAX_NODES-1:0] bits);
        int unsigned node;
        node = 0;
        for (int unsigned lvl = 0; lvl < MAX_IDX_W; lvl++) begin
            if (lvl < idx_w) begin
                node = 2 * node + 1 + 32'(bits[node[2:0]]);
            end
        end
        return MAX_IDX_W'(node - ((32'd1 << idx_w) - 1));
    endfunction

    // Every node on the accessed way's path is made to point away from it.
    function automatic logic [MAX_NODES-1:0] plru_update(input int unsigned idx_w,
                                                         input logic [MAX_NODES-1:0] bits,
                                                         input logic [MAX_IDX_W-1:0] way);
        logic [MAX_NODES-1:0] res;
        int unsigned          node;
        int unsigned          b;
        logic                 dir;
        res  = bits;
        node = 0;
        for (int unsigned lvl = 0; lvl < MAX_IDX_W; lvl++) begin
            if (lvl < idx_w) begin
                b              = idx_w - 1 - lvl;
                dir            = way[b[1:0]];
                res[node[2:0]] = ~dir;
                node           = 2 * node + 1 + 32'(dir);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/l1d_plru_tree.sv
// Combinational tree-PLRU: victim index from the current bits and the bits
// updated for an access to i_way.
module l1d_plru_tree
    import l1d_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS = 4,
    localparam int unsigned IDX_W   = $clog2(NUM_WAYS),
    localparam int unsigned NODES   = NUM_WAYS - 1
) (
    input  logic [NODES-1:0] i_bits,
    input  logic [IDX_W-1:0] i_way,
    output logic [IDX_W-1:0] o_victim,
    output logic [NODES-1:0] o_bits
);

    assign o_victim = IDX_W'(plru_victim(IDX_W, MAX_NODES'(i_bits)));
    assign o_bits   = NODES'(plru_update(IDX_W, MAX_NODES'(i_bits), MAX_IDX_W'(i_way)));

endmodule

// File: rtl/l1d_cache_control_nway.sv
// N-way L1D cache controller: hit service, write-back of a dirty victim, line fill,
// tree-PLRU maintenance and saturating performance counters.
module l1d_cache_control_nway
    import l1d_cache_pkg::*;
#(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned COUNT_W    = 32,
    localparam int unsigned WAY_IDX_W = $clog2(NUM_WAYS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    input  logic [NUM_WAYS-1:0]  hit_way,
    input  logic [NUM_WAYS-1:0]  valid_out,
    input  logic [NUM_WAYS-1:0]  dirty_out,
    input  logic [NUM_WAYS-2:0]  plru_out,
    output logic [NUM_WAYS-2:0]  plru_in,
    output logic                 plru_W,
    output logic [NUM_WAYS-1:0]  data_W,
    output logic [NUM_WAYS-1:0]  tag_W,
    output logic [NUM_WAYS-1:0]  valid_W,
    output logic [NUM_WAYS-1:0]  dirty_W,
    output logic                 dirty_in,
    output logic                 data_in_mux_sel,
    output logic [WAY_IDX_W-1:0] way_sel,
    output logic                 pmem_addr_mux_sel,
    output logic                 load_mdr,
    output logic                 load_pmem_data_out,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit_clear,
    input  logic                 miss_clear,
    input  logic                 wb_clear,
    output logic [COUNT_W-1:0]   hit_count,
    output logic [COUNT_W-1:0]   miss_count,
    output logic [COUNT_W-1:0]   wb_count
);

    state_e               r_state;
    state_e               w_next;
    logic [WAY_IDX_W-1:0] r_victim;
    logic [WAY_IDX_W-1:0] w_victim;
    logic [WAY_IDX_W-1:0] w_hit_idx;
    logic [WAY_IDX_W-1:0] w_inv_idx;
    logic [WAY_IDX_W-1:0] w_plru_victim;
    logic [WAY_IDX_W-1:0] w_upd_way;
    logic [WAY_IDX_W-1:0] w_unused_victim;
    logic [NUM_WAYS-2:0]  w_upd_bits;
    logic [NUM_WAYS-2:0]  w_unused_bits;
    logic [NUM_WAYS-1:0]  w_victim_oh;
    logic                 w_any_inv;
    logic                 w_req;
    logic                 w_hit;
    logic                 w_victim_dirty;
    logic [COUNT_W-1:0]   r_hit_count;
    logic [COUNT_W-1:0]   r_miss_count;
    logic [COUNT_W-1:0]   r_wb_count;

    assign w_req = mem_read | mem_write;
    assign w_hit = |hit_way;

    always_comb begin
        w_hit_idx = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (hit_way[i]) w_hit_idx = w_hit_idx | WAY_IDX_W'(i);
        end
    end

    // Scan downwards so the lowest invalid way wins.
    always_comb begin
        w_any_inv = 1'b0;
        w_inv_idx = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (!valid_out[i]) begin
                w_any_inv = 1'b1;
                w_inv_idx = WAY_IDX_W'(i);
            end
        end
    end

    assign w_upd_way = (r_state == FILL_WRITE) ? r_victim : w_hit_idx;

    l1d_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_update (
        .i_bits   (plru_out),
        .i_way    (w_upd_way),
        .o_victim (w_unused_victim),
        .o_bits   (w_upd_bits)
    );

    l1d_plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru_victim (
        .i_bits   (plru_out),
        .i_way    (w_hit_idx),
        .o_victim (w_plru_victim),
        .o_bits   (w_unused_bits)
    );

    assign w_victim       = w_any_inv ? w_inv_idx : w_plru_victim;
    assign w_victim_dirty = valid_out[w_victim] & dirty_out[w_victim];
    assign w_victim_oh    = NUM_WAYS'(1) << r_victim;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= READY;
            r_victim <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == READY && w_req && !w_hit) r_victim <= w_victim;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            READY:      if (w_req && !w_hit) w_next = w_victim_dirty ? WB_LOAD : FILL_READ;
            WB_LOAD:    w_next = WB_WRITE;
            WB_WRITE:   if (pmem_resp) w_next = FILL_READ;
            FILL_READ:  if (pmem_resp) w_next = FILL_WRITE;
            FILL_WRITE: w_next = READY;
            default:    w_next = READY;
        endcase
    end

    // Outputs are gated by rst_n so nothing leaks out while reset is held.
    always_comb begin
        mem_resp           = 1'b0;
        plru_in            = '0;
        plru_W             = 1'b0;
        data_W             = '0;
        tag_W              = '0;
        valid_W            = '0;
        dirty_W            = '0;
        dirty_in           = 1'b0;
        data_in_mux_sel    = 1'b0;
        way_sel            = '0;
        pmem_addr_mux_sel  = 1'b0;
        load_mdr           = 1'b0;
        load_pmem_data_out = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        if (rst_n) begin
            unique case (r_state)
                READY: begin
                    if (w_req && w_hit) begin
                        mem_resp = 1'b1;
                        plru_W   = 1'b1;
                        plru_in  = w_upd_bits;
                        if (mem_write) begin
                            data_W   = hit_way;
                            dirty_W  = hit_way;
                            dirty_in = 1'b1;
                        end
                    end
                end
                WB_LOAD: begin
                    load_pmem_data_out = 1'b1;
                    way_sel            = r_victim;
                end
                WB_WRITE: begin
                    pmem_write        = 1'b1;
                    pmem_addr_mux_sel = 1'b1;
                    way_sel           = r_victim;
                end
                FILL_READ: begin
                    pmem_read = 1'b1;
                    load_mdr  = pmem_resp;
                end
                FILL_WRITE: begin
                    data_W          = w_victim_oh;
                    tag_W           = w_victim_oh;
                    valid_W         = w_victim_oh;
                    dirty_W         = w_victim_oh;
                    data_in_mux_sel = 1'b1;
                    plru_W          = 1'b1;
                    plru_in         = w_upd_bits;
                end
                default: ;
            endcase
        end
    end

    function automatic logic [COUNT_W-1:0] cnt_next(input logic [COUNT_W-1:0] cur,
                                                    input logic clr, input logic inc);
        if (clr) return '0;
        if (inc && cur != '1) return cur + COUNT_W'(1);
        return cur;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_wb_count   <= '0;
        end else begin
            r_hit_count  <= cnt_next(r_hit_count, hit_clear, r_state == READY && w_req && w_hit);
            r_miss_count <= cnt_next(r_miss_count, miss_clear, r_state == FILL_WRITE);
            r_wb_count   <= cnt_next(r_wb_count, wb_clear, r_state == WB_WRITE && pmem_resp);
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
    assign wb_count   = r_wb_count;

    a_hit_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(hit_way))
        else $error("hit_way has more than one bit set");

endmodule

// File: tb/tb_l1d_cache_control_nway.sv
// Scoreboard bench for l1d_cache_control_nway (4 ways) with a fixed-latency memory model.
module tb_l1d_cache_control_nway;

    localparam int WR_LAT = 4;
    localparam int RD_LAT = 2;

    typedef struct packed {
        logic [2:0] plru;
        logic [3:0] wr_mask;
        logic       din;
    } resp_t;

    typedef struct packed {
        logic [3:0] oh;
        logic [2:0] plru;
    } fill_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write, mem_resp;
    logic [3:0]  hit_way, valid_out, dirty_out;
    logic [2:0]  plru_out, plru_in;
    logic        plru_W;
    logic [3:0]  data_W, tag_W, valid_W, dirty_W;
    logic        dirty_in, data_in_mux_sel;
    logic [1:0]  way_sel;
    logic        pmem_addr_mux_sel, load_mdr, load_pmem_data_out;
    logic        pmem_read, pmem_write;
    logic        pmem_resp = 1'b0;
    logic        hit_clear, miss_clear, wb_clear;
    logic [31:0] hit_count, miss_count, wb_count;
    logic [29:0] all_outs;

    resp_t q_resp[$];
    fill_t q_fill[$];
    int    q_wb[$];
    int    n_checks = 0;
    int    n_fail = 0;
    int    op_cycles = 0;

    always #5 clk = ~clk;

    l1d_cache_control_nway #(.NUM_WAYS(4), .COUNT_W(32)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .mem_read           (mem_read),
        .mem_write          (mem_write),
        .mem_resp           (mem_resp),
        .hit_way            (hit_way),
        .valid_out          (valid_out),
        .dirty_out          (dirty_out),
        .plru_out           (plru_out),
        .plru_in            (plru_in),
        .plru_W             (plru_W),
        .data_W             (data_W),
        .tag_W              (tag_W),
        .valid_W            (valid_W),
        .dirty_W            (dirty_W),
        .dirty_in           (dirty_in),
        .data_in_mux_sel    (data_in_mux_sel),
        .way_sel            (way_sel),
        .pmem_addr_mux_sel  (pmem_addr_mux_sel),
        .load_mdr           (load_mdr),
        .load_pmem_data_out (load_pmem_data_out),
        .pmem_read          (pmem_read),
        .pmem_write         (pmem_write),
        .pmem_resp          (pmem_resp),
        .hit_clear          (hit_clear),
        .miss_clear         (miss_clear),
        .wb_clear           (wb_clear),
        .hit_count          (hit_count),
        .miss_count         (miss_count),
        .wb_count           (wb_count)
    );

    assign all_outs = {mem_resp, plru_in, plru_W, data_W, tag_W, valid_W, dirty_W, dirty_in,
                       data_in_mux_sel, way_sel, pmem_addr_mux_sel, load_mdr,
                       load_pmem_data_out, pmem_read, pmem_write};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory model: answers after a fixed number of cycles of pmem_read/pmem_write.
    always @(posedge clk) begin
        #2;
        if (pmem_resp || !rst_n) op_cycles = 0;
        if (rst_n && (pmem_read || pmem_write)) op_cycles++;
        else op_cycles = 0;
        pmem_resp = rst_n && ((pmem_write && op_cycles == WR_LAT) ||
                              (pmem_read && op_cycles == RD_LAT));
    end

    always @(negedge clk) begin
        if (mem_resp) begin
            check("resp_expected", 64'(q_resp.size() != 0), 1);
            if (q_resp.size() != 0) begin
                resp_t e;
                e = q_resp.pop_front();
                check("hit_resp", {plru_in, plru_W, data_W, dirty_W, dirty_in, data_in_mux_sel,
                                   tag_W, valid_W},
                      {e.plru, 1'b1, e.wr_mask, e.wr_mask, e.din, 1'b0, 4'b0, 4'b0});
            end
        end
        if (valid_W != 4'b0) begin
            check("fill_expected", 64'(q_fill.size() != 0), 1);
            if (q_fill.size() != 0) begin
                fill_t f;
                f = q_fill.pop_front();
                check("fill_write", {data_W, tag_W, valid_W, dirty_W, dirty_in, data_in_mux_sel,
                                     plru_W, plru_in, mem_resp},
                      {f.oh, f.oh, f.oh, f.oh, 1'b0, 1'b1, 1'b1, f.plru, 1'b0});
            end
        end
        if (load_pmem_data_out || pmem_write) begin
            check("wb_expected", 64'(q_wb.size() != 0), 1);
            if (q_wb.size() != 0) begin
                check("wb_way_sel", 64'(way_sel), 64'(q_wb[0]));
                if (pmem_write) begin
                    check("wb_addr_sel", 64'(pmem_addr_mux_sel), 1);
                    if (pmem_resp) void'(q_wb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        hit_way    = 4'b0;
        hit_clear  = 1'b0;
        miss_clear = 1'b0;
        wb_clear   = 1'b0;
    endtask

    task automatic do_hit(input logic rd, input logic wr, input logic [3:0] hw,
                          input logic [2:0] plru, input logic clr, input resp_t exp);
        tick();
        q_resp.push_back(exp);
        mem_read  = rd;
        mem_write = wr;
        hit_way   = hw;
        plru_out  = plru;
        valid_out = 4'b1111;
        dirty_out = 4'b0000;
        hit_clear = clr;
        tick();
        idle();
    endtask

    task automatic do_miss(input logic rd, input logic wr, input logic [3:0] val,
                           input logic [3:0] dty, input logic [2:0] plru, input int victim,
                           input logic [2:0] fill_plru, input logic wb, input int exp_wait,
                           input resp_t exp);
        fill_t f;
        int    n;
        logic  found;
        tick();
        f.oh   = 4'b0001 << victim;
        f.plru = fill_plru;
        q_fill.push_back(f);
        if (wb) q_wb.push_back(victim);
        q_resp.push_back(exp);
        mem_read  = rd;
        mem_write = wr;
        hit_way   = 4'b0;
        valid_out = val;
        dirty_out = dty;
        plru_out  = plru;
        found     = 1'b0;
        n         = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (valid_W != 4'b0) begin
                found = 1'b1;
                n     = k;
                break;
            end
        end
        check("miss_fill_reached", 64'(found), 1);
        check("miss_latency", 64'(n), 64'(exp_wait));
        tick();
        hit_way = f.oh;
        tick();
        idle();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic found;
        rst_n     = 1'b0;
        idle();
        mem_write = 1'b1;
        hit_way   = 4'b0001;
        plru_out  = 3'b101;
        valid_out = 4'b1111;
        dirty_out = 4'b1111;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", 64'(all_outs), 0);
        end
        check("reset_hit_count", 64'(hit_count), 0);
        check("reset_miss_count", 64'(miss_count), 0);
        check("reset_wb_count", 64'(wb_count), 0);
        tick();
        idle();
        rst_n = 1'b1;

        do_hit(1, 0, 4'b0100, 3'b000, 0, '{plru: 3'b100, wr_mask: 4'b0000, din: 1'b0});
        check("read_hit_count", 64'(hit_count), 1);

        do_miss(1, 0, 4'b1111, 4'b0100, 3'b011, 2, 3'b110, 1, 8,
                '{plru: 3'b110, wr_mask: 4'b0000, din: 1'b0});
        check("dirty_hit_count", 64'(hit_count), 2);
        check("dirty_miss_count", 64'(miss_count), 1);
        check("dirty_wb_count", 64'(wb_count), 1);

        do_miss(1, 0, 4'b1011, 4'b1111, 3'b101, 2, 3'b100, 0, 3,
                '{plru: 3'b100, wr_mask: 4'b0000, din: 1'b0});
        check("inv_miss_count", 64'(miss_count), 2);
        check("inv_wb_count", 64'(wb_count), 1);

        do_hit(0, 1, 4'b0001, 3'b000, 1, '{plru: 3'b011, wr_mask: 4'b0001, din: 1'b1});
        check("hit_clear_priority", 64'(hit_count), 0);

        do_hit(1, 1, 4'b1000, 3'b111, 0, '{plru: 3'b010, wr_mask: 4'b1000, din: 1'b1});
        check("rdwr_hit_count", 64'(hit_count), 1);

        do_miss(0, 1, 4'b1111, 4'b0000, 3'b000, 0, 3'b011, 0, 3,
                '{plru: 3'b011, wr_mask: 4'b0001, din: 1'b1});
        check("plru_miss_count", 64'(miss_count), 3);
        check("plru_hit_count", 64'(hit_count), 2);

        tick();
        q_resp.push_back('{plru: 3'b001, wr_mask: 4'b0000, din: 1'b0});
        mem_read   = 1'b1;
        hit_way    = 4'b0010;
        plru_out   = 3'b000;
        valid_out  = 4'b1111;
        miss_clear = 1'b1;
        wb_clear   = 1'b1;
        tick();
        idle();
        check("miss_clear", 64'(miss_count), 0);
        check("wb_clear", 64'(wb_count), 0);
        check("hit_kept", 64'(hit_count), 3);

        tick();
        q_wb.push_back(2);
        mem_read  = 1'b1;
        hit_way   = 4'b0;
        valid_out = 4'b1111;
        dirty_out = 4'b1111;
        plru_out  = 3'b011;
        found     = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (pmem_write) begin
                found = 1'b1;
                break;
            end
        end
        check("wb_reached", 64'(found), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_mid_pmem_write", 64'(pmem_write), 0);
        check("rst_mid_outputs", 64'(all_outs), 0);
        idle();
        q_wb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_outputs", 64'(all_outs), 0);
        check("post_rst_counts", 64'(hit_count | miss_count | wb_count), 0);

        do_hit(1, 0, 4'b0100, 3'b000, 0, '{plru: 3'b100, wr_mask: 4'b0000, din: 1'b0});
        check("post_rst_hit_count", 64'(hit_count), 1);

        repeat (3) tick();
        check("queues_drained", 64'(q_resp.size() + q_fill.size() + q_wb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
